// File: rtl/seg7_scan.sv
// Time-multiplexed common-anode seven-segment driver: one nibble per digit, dead-time gap
// between digit slots, inputs snapshotted at the start of each frame.
module seg7_scan #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned ON_CYCLES   = 50000,
  parameter int unsigned DEAD_CYCLES = 500
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic [NUM_DIGITS-1:0]   i_blank,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame
);

  localparam int unsigned MaxCyc = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam int unsigned IdxW   = $clog2(NUM_DIGITS);

  localparam logic [CntW-1:0] OnLast   = CntW'(ON_CYCLES - 1);
  localparam logic [CntW-1:0] DeadLast = CntW'(DEAD_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);

  typedef enum logic {StDead, StOn} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] data_snap_q;
  logic [NUM_DIGITS-1:0]   dp_snap_q, blank_snap_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_q, frame_d;

  logic                    frame_start;
  logic [4*NUM_DIGITS-1:0] data_src;
  logic [NUM_DIGITS-1:0]   dp_src, blank_src;
  logic [3:0]              nibble;

  // Active-high segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    idx_d       = idx_q;
    frame_start = 1'b0;
    unique case (state_q)
      StDead: begin
        if (cnt_q == DeadLast) begin
          state_d     = StOn;
          cnt_d       = '0;
          frame_start = (idx_q == '0);
        end
      end
      StOn: begin
        if (cnt_q == OnLast) begin
          state_d = StDead;
          cnt_d   = '0;
          idx_d   = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end
      end
      default: state_d = StDead;
    endcase

    // Digit 0 is shown from the live inputs on the same edge the snapshot is taken.
    data_src  = frame_start ? i_data  : data_snap_q;
    dp_src    = frame_start ? i_dp    : dp_snap_q;
    blank_src = frame_start ? i_blank : blank_snap_q;
    nibble    = data_src[{idx_q, 2'b00} +: 4];

    an_d    = '1;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    frame_d = frame_start;
    if (state_d == StOn) begin
      seg_d = ~decode(nibble);
      dp_d  = ~dp_src[idx_q];
      if (!blank_src[idx_q]) an_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StDead;
      cnt_q        <= '0;
      idx_q        <= '0;
      data_snap_q  <= '0;
      dp_snap_q    <= '0;
      blank_snap_q <= '0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (frame_start) begin
        data_snap_q  <= i_data;
        dp_snap_q    <= i_dp;
        blank_snap_q <= i_blank;
      end
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_d;
    end
  end

  assign o_an    = an_q;
  assign o_seg   = seg_q;
  assign o_dp    = dp_q;
  assign o_frame = frame_q;

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
Time-multiplexed driver for a common-anode multi-digit seven-segment display. It is the output-side counterpart of the board button input path: it takes a packed hex value from core logic, decodes one nibble per digit and scans the digits. Each digit slot is separated by a dead-time gap to suppress ghosting. Inputs are snapshotted once per frame so the displayed value never tears.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
ON_CYCLES, 50000, clock cycles each digit is driven (>=1)
DEAD_CYCLES, 500, clock cycles with all anodes off between digits (>=1)

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous reset, active-high
i_data  input  4*NUM_DIGITS  hex value; nibble n drives digit n, digit 0 = bits [3:0]
i_dp  input  NUM_DIGITS  decimal point per digit, 1 = lit
i_blank  input  NUM_DIGITS  1 = digit n stays dark in its slot
o_an  output  NUM_DIGITS  anode enables, active-low, one-hot-low when driving
o_seg  output  7  segments {g,f,e,d,c,b,a}, active-low
o_dp  output  1  decimal point, active-low
o_frame  output  1  one-cycle pulse at the start of each frame

Behaviour:
- One clock domain. Reset is synchronous and active-high on i_clk/i_rst. All outputs are registered.
- Reset values:
  - o_an all 1s, o_seg 7'h7F, o_dp 1, o_frame 0.
  - FSM in DEAD, digit index 0, cycle counter 0.
  - Snapshot registers cleared to 0.
- FSM, two states:
  - DEAD: counter counts 0..DEAD_CYCLES-1. On the last count go to ON; clear the counter.
  - ON: counter counts 0..ON_CYCLES-1. On the last count go to DEAD and advance the index: idx+1, or 0 when idx = NUM_DIGITS-1.
- The first cycle after i_rst deasserts is DEAD cycle 0. The first digit-0 ON cycle is therefore DEAD_CYCLES cycles after reset release.
- Snapshot on the DEAD->ON edge with idx=0 (start of frame):
  - i_data, i_dp and i_blank are captured.
  - The digit-0 outputs on that same edge come from the live inputs, not the old snapshot.
  - All other digits in the frame use the snapshot. Input changes mid-frame are invisible until the next frame.
- o_frame is 1 for exactly the first ON cycle of digit 0 in every frame.
- Outputs in ON for digit n:
  - o_an[n]=0 and all other anodes 1, unless blank[n]=1, in which case o_an stays all 1s.
  - o_seg = ~decode(nibble n).
  - o_dp = ~dp[n].
- Outputs in DEAD: o_an all 1s, o_seg 7'h7F, o_dp 1.
- Decode table, active-high gfedcba: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Frame period = NUM_DIGITS*(ON_CYCLES+DEAD_CYCLES) cycles, exactly, with no drift.
- Counter width = clog2(max(ON_CYCLES,DEAD_CYCLES)). Index width = clog2(NUM_DIGITS); the index wraps explicitly for non-power-of-2 NUM_DIGITS.
- Reset asserted mid-operation: on the next edge all outputs go off and the FSM restarts at DEAD, idx 0. No partial slot completes.
- Reset wins over every other event on the same edge.

Test Plan:
(Bench parameters: NUM_DIGITS=4, ON_CYCLES=4, DEAD_CYCLES=2.)
1. Reset start: hold i_rst 3 cycles, i_data=16'h1234, release → o_an=4'b1111 for 2 cycles, then 4'b1110 for 4 cycles with o_seg=7'h19 (digit 4) and o_frame high only in the first of those cycles.
2. Full scan order: run 2 frames → o_an sequence 1110,1101,1011,0111, each 4 cycles with 2-cycle 1111 gaps. o_seg for digits 1..3 is 7'h30, 7'h24, 7'h79 (3,2,1). o_frame pulses 24 cycles apart.
3. Tear-free snapshot: set i_data=16'hABCD while digit 1 is driving → digits 1..3 still show 3,2,1. The next frame shows D,C,B,A: o_seg 7'h21, 7'h46, 7'h03, 7'h08.
4. Blank and decimal point: i_blank=4'b0100, i_dp=4'b0001 → digit 2 slot keeps o_an=1111. o_dp=0 only during the digit-0 slot.
5. Reset mid-slot: assert i_rst during ON cycle 2 of digit 2 → next edge o_an=1111, o_seg=7F. After release, the first driven digit is digit 0, after 2 dead cycles.
6. Decode sweep: i_data=16'hF000, then 16'h0E00, and so on through all 16 nibbles → every o_seg matches the inverted decode table, and no anode is ever low during DEAD.
